// File: rtl/decode_pkg.sv
// Shared types for the decode/issue boundary.
// - imm_fmt_e : immediate format selector produced by instruction_decoder
// - NOP_INSTR : canonical bubble (addi x0,x0,0) shown when nothing is issued
// - iq_entry_t: one fully decoded, operand-resolved issue-queue entry
package decode_pkg;

  localparam int IQ_XLEN   = 32;
  localparam int IQ_NREG   = 32;
  localparam int IQ_REG_W  = $clog2(IQ_NREG);
  localparam int IQ_CTRL_W = 24;
  localparam int IQ_DEPTH  = 2;

  localparam logic [IQ_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_e;

  typedef struct packed {
    logic [IQ_XLEN-1:0]   instr;
    logic [IQ_XLEN-1:0]   pc;
    logic [IQ_XLEN-1:0]   next_pc;
    logic [IQ_XLEN-1:0]   opa;
    logic [IQ_XLEN-1:0]   rs2_data;
    logic [IQ_XLEN-1:0]   imm;
    logic [IQ_CTRL_W-1:0] ctrl;
    logic [IQ_REG_W-1:0]  rs1;
    logic [IQ_REG_W-1:0]  rs2;
    logic [IQ_REG_W-1:0]  rd;
    logic                 use_pc;
  } iq_entry_t;

endpackage

// File: rtl/decode_issue_queue_if.sv
// Bundle between decode, writeback and execute around the issue queue.
// - master: driven by the decode/writeback/execute side (inputs of the queue)
// - slave : the queue itself
// Groups the enqueue side (in_*), writeback snoop (wb_*), flush, the
// dequeue side (out_*) and the occupancy count.
interface decode_issue_queue_if
  import decode_pkg::*;
#(
  parameter int XLEN   = IQ_XLEN,
  parameter int NREG   = IQ_NREG,
  parameter int DEPTH  = IQ_DEPTH,
  parameter int CTRL_W = IQ_CTRL_W
);
  localparam int REG_W = $clog2(NREG);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_instr;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_next_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [2:0]        in_imm_fmt;
  logic              in_use_pc;
  logic              wb_en;
  logic [REG_W-1:0]  wb_reg;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_instr;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_next_pc;
  logic [XLEN-1:0]   out_opa;
  logic [XLEN-1:0]   out_rs2_data;
  logic [XLEN-1:0]   out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic [REG_W-1:0]  out_rs1;
  logic [REG_W-1:0]  out_rs2;
  logic [REG_W-1:0]  out_rd;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, in_valid, in_instr, in_pc, in_next_pc, in_ctrl, in_imm_fmt,
           in_use_pc, wb_en, wb_reg, wb_data, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_next_pc, out_opa,
           out_rs2_data, out_imm, out_ctrl, out_rs1, out_rs2, out_rd, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, in_next_pc, in_ctrl, in_imm_fmt,
           in_use_pc, wb_en, wb_reg, wb_data, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_next_pc, out_opa,
           out_rs2_data, out_imm, out_ctrl, out_rs1, out_rs2, out_rd, count
  );

endinterface

// File: rtl/imm_gen.sv
// RV32 immediate generator, purely combinational; also used by the branch unit.
// - instr: 32-bit instruction word
// - fmt  : imm_fmt_e code (kept as raw bits so undefined codes are representable)
// - imm  : sign-extended immediate, 0 for undefined format codes
module imm_gen
  import decode_pkg::*;
(
  input  logic [IQ_XLEN-1:0] instr,
  input  logic [2:0]         fmt,
  output logic [IQ_XLEN-1:0] imm
);

  always_comb begin
    // NOTE: default first so every path assigns imm and no latch is inferred.
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_issue_queue.sv
// Decode-to-execute issue queue with register read, write-through bypass and
// writeback snooping.
// - clk, rst_n : clock, synchronous active-low reset
// - bus (slave): enqueue side in_*, writeback wb_*, flush, dequeue side out_*,
//                occupancy count
// Entries are resolved (operands read, immediate built) on enqueue and kept
// fresh by snooping writeback while they wait. An empty head shows a NOP.
module decode_issue_queue
  import decode_pkg::*;
#(
  parameter int              XLEN   = IQ_XLEN,
  parameter int              NREG   = IQ_NREG,
  parameter int              DEPTH  = IQ_DEPTH,
  parameter int              CTRL_W = IQ_CTRL_W,
  parameter logic [XLEN-1:0] NOP    = NOP_INSTR
) (
  input logic                 clk,
  input logic                 rst_n,
  decode_issue_queue_if.slave bus
);

  localparam int REG_W = $clog2(NREG);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  rf_q [NREG];
  logic [XLEN-1:0]  rf_d [NREG];
  iq_entry_t        mem_q [DEPTH];
  iq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             out_valid, enq, deq, wb_hit;
  logic [XLEN-1:0]  imm;
  logic [REG_W-1:0] rs1, rs2;
  iq_entry_t        new_entry;
  iq_entry_t        head;

  // Register read with write-through of a same-cycle writeback; x0 reads 0.
  function automatic logic [XLEN-1:0] read_reg(
    input logic [REG_W-1:0] idx,
    input logic [XLEN-1:0]  rf_val,
    input logic             hit,
    input logic [REG_W-1:0] wreg,
    input logic [XLEN-1:0]  wdata
  );
    if (idx == '0)                return '0;
    else if (hit && wreg == idx)  return wdata;
    else                          return rf_val;
  endfunction

  // A slot holds a live entry when its distance from the head is below count.
  function automatic logic slot_live(
    input logic [PTR_W-1:0] slot,
    input logic [PTR_W-1:0] rd_ptr,
    input logic [CNT_W-1:0] cnt
  );
    logic [PTR_W-1:0] off;
    off = slot - rd_ptr;
    return {1'b0, off} < cnt;
  endfunction

  assign out_valid    = (count_q != '0);
  assign bus.in_ready = (count_q < CNT_W'(DEPTH)) || bus.out_ready;
  assign enq          = bus.in_valid && bus.in_ready && !bus.flush;
  assign deq          = out_valid && bus.out_ready && !bus.flush;
  assign wb_hit       = bus.wb_en && (bus.wb_reg != '0);

  imm_gen u_imm_gen (
    .instr (bus.in_instr),
    .fmt   (bus.in_imm_fmt),
    .imm   (imm)
  );

  always_comb begin
    rs1                = REG_W'(bus.in_instr[19:15]);
    rs2                = REG_W'(bus.in_instr[24:20]);
    new_entry          = '0;
    new_entry.instr    = bus.in_instr;
    new_entry.pc       = bus.in_pc;
    new_entry.next_pc  = bus.in_next_pc;
    new_entry.opa      = bus.in_use_pc ? bus.in_pc
                       : read_reg(rs1, rf_q[rs1], wb_hit, bus.wb_reg, bus.wb_data);
    new_entry.rs2_data = read_reg(rs2, rf_q[rs2], wb_hit, bus.wb_reg, bus.wb_data);
    new_entry.imm      = imm;
    new_entry.ctrl     = bus.in_ctrl;
    new_entry.rs1      = rs1;
    new_entry.rs2      = rs2;
    new_entry.rd       = REG_W'(bus.in_instr[11:7]);
    new_entry.use_pc   = bus.in_use_pc;
  end

  // Writes to x0 are dropped; flush does not block register file updates.
  always_comb begin
    rf_d = rf_q;
    if (wb_hit) rf_d[bus.wb_reg] = bus.wb_data;
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    // Snoop: waiting entries pick up writeback results; the entry leaving
    // this cycle is skipped. The slot being enqueued already saw the bypass.
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_hit && slot_live(PTR_W'(i), rd_ptr_q, count_q) &&
          !(deq && PTR_W'(i) == rd_ptr_q)) begin
        if (!mem_q[i].use_pc && mem_q[i].rs1 == bus.wb_reg) mem_d[i].opa = bus.wb_data;
        if (mem_q[i].rs2 == bus.wb_reg) mem_d[i].rs2_data = bus.wb_data;
      end
    end

    if (enq) mem_d[wr_ptr_q] = new_entry;

    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rf_q     <= '{default: '0};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rf_q     <= rf_d;
    end
  end

  // NOTE: queue storage is not reset; count gates validity and the empty head
  // is masked below, so stale contents are never observable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head             = mem_q[rd_ptr_q];
    bus.out_valid    = out_valid;
    bus.out_instr    = NOP;
    bus.out_pc       = '0;
    bus.out_next_pc  = '0;
    bus.out_opa      = '0;
    bus.out_rs2_data = '0;
    bus.out_imm      = '0;
    bus.out_ctrl     = '0;
    bus.out_rs1      = '0;
    bus.out_rs2      = '0;
    bus.out_rd       = '0;
    if (out_valid) begin
      bus.out_instr    = head.instr;
      bus.out_pc       = head.pc;
      bus.out_next_pc  = head.next_pc;
      bus.out_opa      = head.opa;
      bus.out_rs2_data = head.rs2_data;
      bus.out_imm      = head.imm;
      bus.out_ctrl     = head.ctrl;
      bus.out_rs1      = head.rs1;
      bus.out_rs2      = head.rs2;
      bus.out_rd       = head.rd;
    end
  end

  assign bus.count = count_q;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed self-checking bench for decode_issue_queue (DEPTH=2 defaults).
module tb_decode_issue_queue;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  decode_issue_queue_if bus ();

  decode_issue_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_pc      = '0;
    bus.in_next_pc = '0;
    bus.in_ctrl    = '0;
    bus.in_imm_fmt = '0;
    bus.in_use_pc  = 1'b0;
    bus.wb_en      = 1'b0;
    bus.wb_reg     = '0;
    bus.wb_data    = '0;
    bus.out_ready  = 1'b0;
  endtask

  // Control bundle is an arbitrary pattern derived from the pc.
  function automatic logic [23:0] ctrl_of(input logic [31:0] pc);
    return pc[23:0] ^ 24'h5A5A5A;
  endfunction

  task automatic offer(input logic [31:0] instr, input logic [2:0] fmt,
                       input logic [31:0] pc, input logic use_pc);
    bus.in_valid   = 1'b1;
    bus.in_instr   = instr;
    bus.in_imm_fmt = fmt;
    bus.in_pc      = pc;
    bus.in_next_pc = pc + 32'd4;
    bus.in_ctrl    = ctrl_of(pc);
    bus.in_use_pc  = use_pc;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_reg = r; bus.wb_data = d;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    offer(32'h00500093, IMM_I, 32'h40, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_valid got=%0h exp=0", bus.out_valid); else n_pass++; n_checks++;
    if (bus.out_instr !== 32'h13) $display("FAIL rst_instr got=%h exp=00000013", bus.out_instr); else n_pass++; n_checks++;
    if (bus.count !== 2'd0) $display("FAIL rst_count got=%0d exp=0", bus.count); else n_pass++; n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0h exp=1", bus.in_ready); else n_pass++; n_checks++;
    if ({bus.out_pc, bus.out_opa, bus.out_imm} !== 96'd0) $display("FAIL rst_fields got=%h exp=0", {bus.out_pc, bus.out_opa, bus.out_imm}); else n_pass++; n_checks++;
    if (bus.out_rd !== 5'd0) $display("FAIL rst_rd got=%0d exp=0", bus.out_rd); else n_pass++; n_checks++;
    tick();
    if (bus.count !== 2'd0) $display("FAIL idle_count got=%0d exp=0", bus.count); else n_pass++; n_checks++;
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    offer(32'h00500093, IMM_I, 32'h100, 1'b0);
    #1;
    if (bus.in_ready !== 1'b1) $display("FAIL single_in_ready got=%0h exp=1", bus.in_ready); else n_pass++; n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL single_no_fallthrough got=%0h exp=0", bus.out_valid); else n_pass++; n_checks++;
    tick();
    bus.in_valid = 1'b0;
    if (bus.out_valid !== 1'b1) $display("FAIL single_valid got=%0h exp=1", bus.out_valid); else n_pass++; n_checks++;
    if (bus.out_imm !== 32'd5) $display("FAIL single_imm got=%h exp=5", bus.out_imm); else n_pass++; n_checks++;
    if (bus.out_rd !== 5'd1) $display("FAIL single_rd got=%0d exp=1", bus.out_rd); else n_pass++; n_checks++;
    if (bus.out_instr !== 32'h00500093) $display("FAIL single_instr got=%h exp=00500093", bus.out_instr); else n_pass++; n_checks++;
    if (bus.out_next_pc !== 32'h104) $display("FAIL single_next_pc got=%h exp=104", bus.out_next_pc); else n_pass++; n_checks++;
    if (bus.out_ctrl !== ctrl_of(32'h100)) $display("FAIL single_ctrl got=%h exp=%h", bus.out_ctrl, ctrl_of(32'h100)); else n_pass++; n_checks++;
    if (bus.count !== 2'd1) $display("FAIL single_count got=%0d exp=1", bus.count); else n_pass++; n_checks++;
    tick();
    if (bus.out_valid !== 1'b0) $display("FAIL single_drain_valid got=%0h exp=0", bus.out_valid); else n_pass++; n_checks++;
    if (bus.out_instr !== 32'h13) $display("FAIL single_drain_instr got=%h exp=00000013", bus.out_instr); else n_pass++; n_checks++;
    if (bus.out_imm !== 32'd0) $display("FAIL single_drain_imm got=%h exp=0", bus.out_imm); else n_pass++; n_checks++;
  endtask

  task automatic test_fill();
    bus.out_ready = 1'b0;
    offer(32'h00100113, IMM_I, 32'h200, 1'b0);
    tick();
    if (bus.count !== 2'd1) $display("FAIL fill_count1 got=%0d exp=1", bus.count); else n_pass++; n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL fill_ready1 got=%0h exp=1", bus.in_ready); else n_pass++; n_checks++;
    offer(32'h00200193, IMM_I, 32'h204, 1'b0);
    tick();
    if (bus.count !== 2'd2) $display("FAIL fill_count2 got=%0d exp=2", bus.count); else n_pass++; n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL fill_ready_full got=%0h exp=0", bus.in_ready); else n_pass++; n_checks++;
    offer(32'h00300213, IMM_I, 32'h208, 1'b0);
    tick();
    if (bus.count !== 2'd2) $display("FAIL fill_hold_count got=%0d exp=2", bus.count); else n_pass++; n_checks++;
    if (bus.out_pc !== 32'h200) $display("FAIL fill_hold_head got=%h exp=200", bus.out_pc); else n_pass++; n_checks++;
    bus.out_ready = 1'b1;
    #1;
    if (bus.in_ready !== 1'b1) $display("FAIL fill_ready_full_deq got=%0h exp=1", bus.in_ready); else n_pass++; n_checks++;
    tick();
    if (bus.count !== 2'd2) $display("FAIL fill_swap_count got=%0d exp=2", bus.count); else n_pass++; n_checks++;
    if (bus.out_pc !== 32'h204) $display("FAIL fill_order1 got=%h exp=204", bus.out_pc); else n_pass++; n_checks++;
    bus.in_valid = 1'b0;
    tick();
    if (bus.out_pc !== 32'h208) $display("FAIL fill_order2 got=%h exp=208", bus.out_pc); else n_pass++; n_checks++;
    if (bus.out_imm !== 32'd3) $display("FAIL fill_imm3 got=%h exp=3", bus.out_imm); else n_pass++; n_checks++;
    if (bus.count !== 2'd1) $display("FAIL fill_count_tail got=%0d exp=1", bus.count); else n_pass++; n_checks++;
    tick();
    if (bus.count !== 2'd0) $display("FAIL fill_empty got=%0d exp=0", bus.count); else n_pass++; n_checks++;
  endtask

  task automatic test_bypass_snoop();
    bus.out_ready = 1'b0;
    wb(5'd5, 32'hDEADBEEF);
    offer(32'h00528333, IMM_I, 32'h300, 1'b0);   // add x6,x5,x5
    tick();
    bus.wb_en = 1'b0;
    offer(32'h00528333, IMM_I, 32'h304, 1'b0);   // reads x5 from the register file
    tick();
    bus.in_valid = 1'b0;
    if (bus.out_opa !== 32'hDEADBEEF) $display("FAIL bypass_opa got=%h exp=deadbeef", bus.out_opa); else n_pass++; n_checks++;
    if (bus.out_rs2_data !== 32'hDEADBEEF) $display("FAIL bypass_rs2 got=%h exp=deadbeef", bus.out_rs2_data); else n_pass++; n_checks++;
    if ({bus.out_rs1, bus.out_rs2, bus.out_rd} !== {5'd5, 5'd5, 5'd6}) $display("FAIL bypass_idx got=%h exp=%h", {bus.out_rs1, bus.out_rs2, bus.out_rd}, {5'd5, 5'd5, 5'd6}); else n_pass++; n_checks++;
    wb(5'd5, 32'h1234);
    tick();
    bus.wb_en = 1'b0;
    if (bus.out_opa !== 32'h1234) $display("FAIL snoop_opa got=%h exp=1234", bus.out_opa); else n_pass++; n_checks++;
    if (bus.out_rs2_data !== 32'h1234) $display("FAIL snoop_rs2 got=%h exp=1234", bus.out_rs2_data); else n_pass++; n_checks++;
    if (bus.out_pc !== 32'h300) $display("FAIL snoop_stall_pc got=%h exp=300", bus.out_pc); else n_pass++; n_checks++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    if (bus.out_pc !== 32'h304) $display("FAIL snoop2_pc got=%h exp=304", bus.out_pc); else n_pass++; n_checks++;
    if (bus.out_opa !== 32'h1234) $display("FAIL snoop2_opa got=%h exp=1234", bus.out_opa); else n_pass++; n_checks++;
    if (bus.out_rs2_data !== 32'h1234) $display("FAIL snoop2_rs2 got=%h exp=1234", bus.out_rs2_data); else n_pass++; n_checks++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    offer(32'h12345397, IMM_U, 32'h400, 1'b1);   // auipc x7,0x12345 (rs1 field = 8)
    tick();
    bus.in_valid = 1'b0;
    if (bus.out_opa !== 32'h400) $display("FAIL usepc_opa got=%h exp=400", bus.out_opa); else n_pass++; n_checks++;
    if (bus.out_imm !== 32'h12345000) $display("FAIL usepc_imm got=%h exp=12345000", bus.out_imm); else n_pass++; n_checks++;
    wb(5'd8, 32'h55);
    tick();
    bus.wb_en = 1'b0;
    if (bus.out_opa !== 32'h400) $display("FAIL usepc_no_snoop got=%h exp=400", bus.out_opa); else n_pass++; n_checks++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    if (bus.count !== 2'd0) $display("FAIL bypass_drain got=%0d exp=0", bus.count); else n_pass++; n_checks++;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    offer(32'h00100113, IMM_I, 32'h500, 1'b0);
    tick();
    offer(32'h00200193, IMM_I, 32'h504, 1'b0);
    tick();
    bus.out_ready = 1'b1;
    offer(32'h00300213, IMM_I, 32'h508, 1'b0);
    bus.flush = 1'b1;
    wb(5'd9, 32'h99);
    tick();
    bus.flush = 1'b0; bus.wb_en = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    if (bus.count !== 2'd0) $display("FAIL flush_count got=%0d exp=0", bus.count); else n_pass++; n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_valid got=%0h exp=0", bus.out_valid); else n_pass++; n_checks++;
    if (bus.out_instr !== 32'h13) $display("FAIL flush_instr got=%h exp=00000013", bus.out_instr); else n_pass++; n_checks++;
    if (bus.out_pc !== 32'h0) $display("FAIL flush_pc got=%h exp=0", bus.out_pc); else n_pass++; n_checks++;
    tick();
    if (bus.count !== 2'd0) $display("FAIL flush_dropped got=%0d exp=0", bus.count); else n_pass++; n_checks++;
    offer(32'h00048533, IMM_I, 32'h600, 1'b0);   // add x10,x9,x0
    tick();
    bus.in_valid = 1'b0;
    if (bus.out_pc !== 32'h600) $display("FAIL flush_after_pc got=%h exp=600", bus.out_pc); else n_pass++; n_checks++;
    if (bus.out_opa !== 32'h99) $display("FAIL flush_rf_write got=%h exp=99", bus.out_opa); else n_pass++; n_checks++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back_imm();
    logic [31:0] v   [6] = '{32'hFE000EE3, 32'hFE112E23, 32'h800000B7,
                             32'h001000EF, 32'hFFF00093, 32'hFFF00093};
    logic [2:0]  f   [6] = '{IMM_B, IMM_S, IMM_U, IMM_J, IMM_I, 3'd7};
    logic [31:0] exp [6] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h80000000,
                             32'h00000800, 32'hFFFFFFFF, 32'h00000000};
    bus.out_ready = 1'b1;
    offer(v[0], f[0], 32'h700, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_imm !== exp[i]) $display("FAIL imm_%0d got=%h exp=%h", i, bus.out_imm, exp[i]); else n_pass++; n_checks++;
      if (bus.count !== 2'd1) $display("FAIL b2b_count_%0d got=%0d exp=1", i, bus.count); else n_pass++; n_checks++;
      if (i < 5) offer(v[i+1], f[i+1], 32'h700 + 32'(4*(i+1)), 1'b0);
      else bus.in_valid = 1'b0;
    end
    tick();
    if (bus.count !== 2'd0) $display("FAIL b2b_empty got=%0d exp=0", bus.count); else n_pass++; n_checks++;
  endtask

  task automatic test_x0();
    bus.out_ready = 1'b1;
    wb(5'd0, 32'hFFFF);
    offer(32'h00000433, IMM_I, 32'h800, 1'b0);   // add x8,x0,x0
    tick();
    bus.wb_en = 1'b0;
    offer(32'h00000433, IMM_I, 32'h804, 1'b0);
    if ({bus.out_opa, bus.out_rs2_data} !== 64'd0) $display("FAIL x0_bypass got=%h exp=0", {bus.out_opa, bus.out_rs2_data}); else n_pass++; n_checks++;
    tick();
    bus.in_valid = 1'b0;
    if ({bus.out_opa, bus.out_rs2_data} !== 64'd0) $display("FAIL x0_read got=%h exp=0", {bus.out_opa, bus.out_rs2_data}); else n_pass++; n_checks++;
    if (bus.out_pc !== 32'h804) $display("FAIL x0_pc got=%h exp=804", bus.out_pc); else n_pass++; n_checks++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_bypass_snoop();
    test_flush();
    test_back_to_back_imm();
    test_x0();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
